// File: rtl/shift_sched.sv
// -----------------------------------------------------------------------------
// shift_sched
// Arbitrates between two requesters that each want to push a LENGTH-bit word
// into an external serial shift chain. The accepted word is shifted out MSB
// first while the chain's old contents are captured bit by bit from its
// output, then returned as a response.
//
// Optional feature macro: SHIFT_SCHED_PARITY_EN
//   defined   -> o_rsp_parity is the registered even parity of the capture
//   undefined -> o_rsp_parity is tied to 0 and no parity logic is built
//
// Ports
//   i_clk, i_rst                   clock, asynchronous active-high reset
//   i_req0_valid/data, o_req0_ready requester 0 handshake
//   i_req1_valid/data, o_req1_ready requester 1 handshake
//   o_sr_din, o_sr_en, i_sr_dout   serial chain interface
//   o_rsp_valid/data/id/parity     captured old chain contents
//   i_rsp_ready                    response consumer handshake
//   o_busy                         high whenever not in IDLE
// -----------------------------------------------------------------------------
module shift_sched #(
   parameter int LENGTH = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req0_valid,
   input  logic [LENGTH-1:0] i_req0_data,
   output logic              o_req0_ready,
   input  logic              i_req1_valid,
   input  logic [LENGTH-1:0] i_req1_data,
   output logic              o_req1_ready,
   output logic              o_sr_din,
   output logic              o_sr_en,
   input  logic              i_sr_dout,
   output logic              o_rsp_valid,
   output logic [LENGTH-1:0] o_rsp_data,
   output logic              o_rsp_id,
   output logic              o_rsp_parity,
   input  logic              i_rsp_ready,
   output logic              o_busy
);

   localparam int CW = $clog2(LENGTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(LENGTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      RESP
   } state_t;

   state_t            state;
   logic [LENGTH-1:0] tx;
   logic [LENGTH-1:0] capture;
   logic [CW-1:0]     bit_cnt;
   logic              last_grant;
   logic              rsp_id;
   logic              grant1;
   logic              accept;

   // Round-robin choice: requester 1 wins when it is the only one asking, or
   // when both ask and requester 0 was the last one served. The grant is only
   // offered in IDLE, so a valid seen elsewhere simply waits for the next IDLE.
   always_comb begin
      grant1 = i_req1_valid && (!i_req0_valid || !last_grant);
      accept = (state == IDLE) && (i_req0_valid || i_req1_valid);
   end

   assign o_req0_ready = accept && !grant1;
   assign o_req1_ready = accept && grant1;
   assign o_sr_en      = (state == SHIFT);
   assign o_sr_din     = (state == SHIFT) && tx[LENGTH-1];
   assign o_rsp_valid  = (state == RESP);
   assign o_rsp_data   = capture;
   assign o_rsp_id     = rsp_id;
   assign o_busy       = (state != IDLE);

   // Main controller. last_grant resets to 1 so requester 0 wins the first
   // tie. During SHIFT the outgoing word leaves from the top of tx while the
   // chain's old contents enter capture from the bottom; after LENGTH shifts
   // capture holds the chain exactly as it was before the load.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         tx         <= '0;
         capture    <= '0;
         bit_cnt    <= '0;
         last_grant <= 1'b1;
         rsp_id     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  tx         <= grant1 ? i_req1_data : i_req0_data;
                  rsp_id     <= grant1;
                  last_grant <= grant1;
                  bit_cnt    <= '0;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               tx      <= {tx[LENGTH-2:0], 1'b0};
               capture <= {capture[LENGTH-2:0], i_sr_dout};
               bit_cnt <= bit_cnt + CNT_ONE;
               if (bit_cnt == CNT_LAST) begin
                  state <= RESP;
               end
            end
            RESP: begin
               if (i_rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef SHIFT_SCHED_PARITY_EN
   logic rsp_parity;

   // Parity is folded in on the final shift so it lands together with the
   // completed capture word and stays put for the whole response.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rsp_parity <= 1'b0;
      end else if (state == SHIFT && bit_cnt == CNT_LAST) begin
         rsp_parity <= ^{capture[LENGTH-2:0], i_sr_dout};
      end
   end

   assign o_rsp_parity = rsp_parity;
`else
   assign o_rsp_parity = 1'b0;
`endif

endmodule

// File: tb/tb_shift_sched.sv
// -----------------------------------------------------------------------------
// tb_shift_sched
// Self-checking bench for shift_sched with LENGTH=8. The serial chain is
// modelled as a plain 8-bit register that shifts whenever the DUT enables it.
// Expected responses come from the chain value at the moment of acceptance,
// the expected serial stream from the accepted word, and grants from a simple
// "who was served last" round-robin rule.
// -----------------------------------------------------------------------------
module tb_shift_sched;

   localparam int L = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req1_valid;
   logic [L-1:0] req0_data, req1_data;
   logic         req0_ready, req1_ready;
   logic         sr_din, sr_en, sr_dout;
   logic         rsp_valid, rsp_id, rsp_parity, rsp_ready, busy;
   logic [L-1:0] rsp_data;

   logic [L-1:0] chain;
   logic         last_en;
   logic         last_din;
   logic         model_last;
   int           checks;
   int           errors;

   always #5 clk = ~clk;

   assign sr_dout = chain[L-1];

   shift_sched #(.LENGTH(L)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req0_valid (req0_valid),
      .i_req0_data  (req0_data),
      .o_req0_ready (req0_ready),
      .i_req1_valid (req1_valid),
      .i_req1_data  (req1_data),
      .o_req1_ready (req1_ready),
      .o_sr_din     (sr_din),
      .o_sr_en      (sr_en),
      .i_sr_dout    (sr_dout),
      .o_rsp_valid  (rsp_valid),
      .o_rsp_data   (rsp_data),
      .o_rsp_id     (rsp_id),
      .o_rsp_parity (rsp_parity),
      .i_rsp_ready  (rsp_ready),
      .o_busy       (busy)
   );

   // One clock cycle: first let the chain model take the shift that happened
   // on the edge just passed, then drive new inputs, then sample outputs.
   task automatic applyStimulus(input logic r, input logic v0, input logic v1,
                                input logic [L-1:0] d0, input logic [L-1:0] d1,
                                input logic rr);
      @(negedge clk);
      if (last_en) chain = {chain[L-2:0], last_din};
      rst        = r;
      req0_valid = v0;
      req1_valid = v1;
      req0_data  = d0;
      req1_data  = d1;
      rsp_ready  = rr;
      #1;
      last_en  = sr_en;
      last_din = sr_din;
   endtask

   task automatic checkOutput(input string tag, input logic [L-1:0] obs,
                              input logic [L-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic expParity(input logic [L-1:0] v);
`ifdef SHIFT_SCHED_PARITY_EN
      return ^v;
`else
      return 1'b0;
`endif
   endfunction

   task automatic checkQuiet(input string tag);
      checkOutput({tag, "_busy"},  busy, 0);
      checkOutput({tag, "_rdy"},   {req1_ready, req0_ready}, 0);
      checkOutput({tag, "_rspv"},  rsp_valid, 0);
      checkOutput({tag, "_sren"},  sr_en, 0);
      checkOutput({tag, "_srdin"}, sr_din, 0);
      checkOutput({tag, "_data"},  rsp_data, 0);
      checkOutput({tag, "_id"},    rsp_id, 0);
      checkOutput({tag, "_par"},   rsp_parity, 0);
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
      checkQuiet("reset");
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      model_last = 1'b1;
   endtask

   // Full transaction: wait for a grant (bounded), check the serial stream,
   // then the response held for 'hold' cycles before being taken.
   task automatic runTxn(input string tag, input logic v0, input logic v1,
                         input logic [L-1:0] d0, input logic [L-1:0] d1,
                         input int hold);
      logic         expg;
      logic [L-1:0] cap;
      logic [L-1:0] dat;
      int           n;
      expg = (v0 && v1) ? ~model_last : !v0;
      applyStimulus(1'b0, v0, v1, d0, d1, 1'b0);
      checkOutput({tag, "_idle"}, busy, 0);
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
         n++;
         applyStimulus(1'b0, v0, v1, d0, d1, 1'b0);
      end
      if (n >= 20) begin
         checkOutput({tag, "_grant_timeout"}, 1, 0);
         return;
      end
      checkOutput({tag, "_grant"}, {req1_ready, req0_ready}, expg ? 2'b10 : 2'b01);
      cap        = chain;
      dat        = expg ? d1 : d0;
      model_last = expg;
      for (int i = 0; i < L; i++) begin
         applyStimulus(1'b0, v0, v1, d0, d1, 1'b0);
         checkOutput({tag, "_sren"}, sr_en, 1);
         checkOutput({tag, "_din"}, sr_din, dat[L-1-i]);
         checkOutput({tag, "_rdy_shift"}, {req1_ready, req0_ready}, 0);
         checkOutput({tag, "_rspv_early"}, rsp_valid, 0);
      end
      for (int h = 0; h <= hold; h++) begin
         applyStimulus(1'b0, v0, v1, d0, d1, h == hold);
         checkOutput({tag, "_rspv"}, rsp_valid, 1);
         checkOutput({tag, "_rdata"}, rsp_data, cap);
         checkOutput({tag, "_rid"}, rsp_id, expg);
         checkOutput({tag, "_rpar"}, rsp_parity, expParity(cap));
         checkOutput({tag, "_sren_resp"}, sr_en, 0);
         checkOutput({tag, "_rdy_resp"}, {req1_ready, req0_ready}, 0);
      end
   endtask

   initial begin
      logic [L-1:0] r0, r1;
      int           sel;
      checks     = 0;
      errors     = 0;
      chain      = '0;
      last_en    = 1'b0;
      last_din   = 1'b0;
      model_last = 1'b1;
      rst        = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_data  = '0;
      req1_data  = '0;
      rsp_ready  = 1'b0;

      $display("[TB] reset and directed load 0xA5 over chain 0x3C");
      doReset();
      chain = 8'h3C;
      runTxn("dir", 1'b1, 1'b0, 8'hA5, 8'h00, 5);

      $display("[TB] both requesters continuously valid");
      doReset();
      for (int k = 0; k < 4; k++) begin
         r0 = 8'($urandom);
         r1 = 8'($urandom);
         chain = 8'($urandom);
         runTxn("rr", 1'b1, 1'b1, r0, r1, 0);
      end

      $display("[TB] reset in the middle of a shift");
      doReset();
      runTxn("pre", 1'b1, 1'b0, 8'h11, 8'h00, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'hF0, 8'h0F, 1'b0);
      checkOutput("abort_grant", {req1_ready, req0_ready}, 2'b01);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 8'hF0, 8'h0F, 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
      checkQuiet("abort");
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      model_last = 1'b1;
      for (int i = 0; i < L + 2; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
         checkOutput("abort_norsp", rsp_valid, 0);
      end
      chain = 8'h5A;
      runTxn("post", 1'b1, 1'b1, 8'hC3, 8'h3C, 1);

      $display("[TB] parity on captured 0x07");
      chain = 8'h07;
      runTxn("par", 1'b0, 1'b1, 8'h00, 8'hFF, 0);

      $display("[TB] random traffic");
      for (int k = 0; k < 12; k++) begin
         sel   = $urandom_range(1, 3);
         r0    = 8'($urandom);
         r1    = 8'($urandom);
         chain = 8'($urandom);
         runTxn("rnd", sel[0], sel[1], r0, r1, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 Parameter LENGTH, default 32: bit length of the downstream serial shift chain and width of every data word; legal range 2..1024.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset; asynchronous, active-high.
REQ-004 i_req0_valid / i_req1_valid  input  1 each  requester 0/1 has a word to load.
REQ-005 i_req0_data / i_req1_data  input  LENGTH each  word to shift into the chain.
REQ-006 o_req0_ready / o_req1_ready  output  1 each  grant; a word is accepted on a cycle where valid and ready are both 1.
REQ-007 o_sr_din  output  1  serial bit driven into the chain input.
REQ-008 o_sr_en  output  1  chain shift enable; the chain shifts exactly on cycles with o_sr_en=1.
REQ-009 i_sr_dout  input  1  chain output, the registered MSB of the chain.
REQ-010 o_rsp_valid  output  1  captured old chain contents available.
REQ-011 o_rsp_data  output  LENGTH  captured word, first bit out at MSB.
REQ-012 o_rsp_id  output  1  requester whose load produced this response.
REQ-013 o_rsp_parity  output  1  even parity of o_rsp_data; see Configuration.
REQ-014 i_rsp_ready  input  1  consumer accepts the response.
REQ-015 o_busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, SHIFT and RESP.
REQ-017 In IDLE, when at least one valid is high, the block SHALL assert exactly one ready for one cycle, chosen by round-robin: the requester not granted last wins a tie.
REQ-018 On accept, the block SHALL latch the data into the tx register, record the id, clear the bit counter, update the round-robin pointer and move to SHIFT.
REQ-019 In SHIFT, for exactly LENGTH consecutive cycles, the block SHALL drive o_sr_en=1 and o_sr_din=tx[LENGTH-1], and shift tx left by one each cycle, so data goes out MSB first.
REQ-020 On each SHIFT cycle the block SHALL shift capture left and load i_sr_dout into bit 0; after LENGTH cycles, capture equals the pre-load chain contents.
REQ-021 The bit counter SHALL be $clog2(LENGTH) bits wide; on the cycle it equals LENGTH-1, the FSM SHALL move to RESP.
REQ-022 Latency: with accept on cycle T, the shift cycles SHALL be T+1..T+LENGTH and o_rsp_valid SHALL first be high in cycle T+LENGTH+1.
REQ-023 In RESP, o_rsp_valid, o_rsp_data, o_rsp_id and o_rsp_parity SHALL stay stable until a cycle with i_rsp_ready=1; the FSM SHALL then return to IDLE.
REQ-024 Readies SHALL be 0 outside IDLE; valids seen during SHIFT or RESP SHALL be held off, not dropped, and served in a later IDLE.
REQ-025 o_sr_en SHALL be 0 in IDLE and RESP; o_sr_din SHALL be 0 whenever o_sr_en=0.
REQ-026 Back-to-back operation: after a RESP handshake the next accept SHALL occur no earlier than the following cycle, which is spent in IDLE.

Reset
REQ-027 Asserting i_rst SHALL immediately force: IDLE, all outputs 0, counter 0, tx and capture 0, round-robin pointer set so requester 0 wins the next tie.
REQ-028 Reset during SHIFT or RESP SHALL abandon the operation with no response; chain contents are then undefined to the consumer.
REQ-029 After reset release, the first accept SHALL occur no earlier than the first rising edge after deassertion.

Configuration
REQ-030 With SHIFT_SCHED_PARITY_EN defined, o_rsp_parity SHALL be the XOR of all bits of capture, registered and valid with o_rsp_valid.
REQ-031 Without SHIFT_SCHED_PARITY_EN, o_rsp_parity SHALL be constant 0 and no parity logic SHALL be built; all other behaviour is identical.

Verification
REQ-032 Reset, then req0 with LENGTH=8, data 0xA5, chain preloaded 0x3C -> o_sr_din sequence 1,0,1,0,0,1,0,1 over 8 cycles; o_rsp_data=0x3C, id=0, response at T+9.
REQ-033 Both valids high continuously after reset -> grants alternate 0,1,0,1; each rsp_id matches its grant.
REQ-034 Hold i_rsp_ready=0 for 5 cycles in RESP -> response outputs stable, o_sr_en=0, no ready asserted; accept on cycle 6 -> IDLE next.
REQ-035 Assert i_rst at shift bit 3 -> outputs 0 at once, no o_rsp_valid; next request runs normally with requester 0 winning the tie.
REQ-036 With SHIFT_SCHED_PARITY_EN defined, a captured chain value of 0x07 (LENGTH=8) -> o_rsp_parity=1; without the macro -> o_rsp_parity=0.
